vga_stream_gen: RTL

//  Parametrised video timing generator and pixel serialiser. Any mode via timing

---
 rtl/vga_stream_gen.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/vga_stream_gen.sv
// Video timing generator and pixel serialiser: pulls packed pixel words over valid/ready,
// expands RGB332/RGB565 to 8-bit RGB, and produces registered syncs, blank and a frame pulse.
module vga_stream_gen #(
  parameter int C_h_visible  = 640,
  parameter int C_h_front    = 16,
  parameter int C_h_sync     = 96,
  parameter int C_h_back     = 48,
  parameter int C_v_visible  = 480,
  parameter int C_v_front    = 10,
  parameter int C_v_sync     = 2,
  parameter int C_v_back     = 33,
  parameter int C_h_sync_pol = 0,
  parameter int C_v_sync_pol = 0,
  parameter int C_bpp        = 8,
  parameter int C_word_bits  = 32,
  parameter int C_dbl_x      = 0
) (
  input  logic                   clk_pixel,
  input  logic                   reset,
  input  logic                   test_mode,
  input  logic [C_word_bits-1:0] data_in,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic [7:0]             vga_r,
  output logic [7:0]             vga_g,
  output logic [7:0]             vga_b,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic                   vga_blank,
  output logic                   frame_start,
  output logic [15:0]            underflow_cnt
);

  localparam int H_TOTAL = C_h_visible + C_h_front + C_h_sync + C_h_back;
  localparam int V_TOTAL = C_v_visible + C_v_front + C_v_sync + C_v_back;
  localparam int PPW     = C_word_bits / C_bpp;
  localparam int BAR_W   = C_h_visible / 8;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int PW      = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0] H_VIS  = HW'(C_h_visible);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(C_h_visible + C_h_front);
  localparam logic [HW-1:0] HS_END = HW'(C_h_visible + C_h_front + C_h_sync);
  localparam logic [VW-1:0] V_VIS  = VW'(C_v_visible);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(C_v_visible + C_v_front);
  localparam logic [VW-1:0] VS_END = VW'(C_v_visible + C_v_front + C_v_sync);
  localparam logic [PW-1:0] P_LAST = PW'(PPW - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BAR_W - 1);
  localparam logic          HS_ON  = 1'(C_h_sync_pol);
  localparam logic          VS_ON  = 1'(C_v_sync_pol);

  logic [HW-1:0]          cx;
  logic [VW-1:0]          cy;
  logic                   ph;
  logic [PW-1:0]          pi;
  logic [BW-1:0]          bar_cnt;
  logic [2:0]             bar_idx;
  logic                   tm_q;
  logic                   miss_q;
  logic [C_word_bits-1:0] sh;

  logic                   visible, hs_act, vs_act, tm_line, fetch, ph_last;
  logic [C_bpp-1:0]       pix;
  logic [7:0]             px_r, px_g, px_b;

  // Handshake: a word transfers on any cycle with data_valid && data_ready; data_ready is
  // raised only at the first clock of each word slot, and a missing word is never retried.
  always_comb begin
    visible = (cx < H_VIS) && (cy < V_VIS);
    hs_act  = (cx >= HS_BEG) && (cx < HS_END);
    vs_act  = (cy >= VS_BEG) && (cy < VS_END);
    tm_line = (cx == '0) ? test_mode : tm_q;
    ph_last = (C_dbl_x != 0) ? ph : 1'b1;
    fetch   = !reset && visible && !tm_line && (pi == '0) && !ph;
    pix     = '0;
    if (fetch) begin
      if (data_valid) pix = data_in[C_bpp-1:0];
    end else if (!miss_q) begin
      pix = sh[C_bpp-1:0];
    end
  end

  assign data_ready = fetch;

  if (C_bpp == 16) begin : g_rgb565
    always_comb begin
      px_r = {pix[15:11], pix[15:13]};
      px_g = {pix[10:5], pix[10:9]};
      px_b = {pix[4:0], pix[4:2]};
    end
  end else begin : g_rgb332
    always_comb begin
      px_r = {pix[7:5], pix[7:5], pix[7:6]};
      px_g = {pix[4:2], pix[4:2], pix[4:3]};
      px_b = {4{pix[1:0]}};
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      cx            <= '0;
      cy            <= '0;
      ph            <= 1'b0;
      pi            <= '0;
      bar_cnt       <= '0;
      bar_idx       <= '0;
      tm_q          <= 1'b0;
      miss_q        <= 1'b0;
      sh            <= '0;
      underflow_cnt <= '0;
      vga_r         <= '0;
      vga_g         <= '0;
      vga_b         <= '0;
      vga_blank     <= 1'b1;
      vga_hsync     <= ~HS_ON;
      vga_vsync     <= ~VS_ON;
      frame_start   <= 1'b0;
    end else begin
      tm_q <= tm_line;
      // Slot and bar counters restart at every line so they stay aligned to cx.
      if (cx == H_LAST) begin
        cx      <= '0;
        cy      <= (cy == V_LAST) ? '0 : cy + 1'b1;
        ph      <= 1'b0;
        pi      <= '0;
        bar_cnt <= '0;
        bar_idx <= '0;
      end else begin
        cx <= cx + 1'b1;
        if (C_dbl_x != 0) ph <= ~ph;
        if (ph_last) pi <= (pi == P_LAST) ? '0 : pi + 1'b1;
        if (bar_cnt == B_LAST) begin
          bar_cnt <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_cnt <= bar_cnt + 1'b1;
        end
      end

      // Pixel 0 of a fetched word goes straight out, so the register holds the word
      // already advanced when the first pixel lasts only one clock.
      if (fetch) begin
        sh     <= ph_last ? (data_in >> C_bpp) : data_in;
        miss_q <= !data_valid;
        if (!data_valid && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
      end else if (ph_last) begin
        sh <= sh >> C_bpp;
      end

      vga_blank   <= !visible;
      vga_hsync   <= hs_act ? HS_ON : ~HS_ON;
      vga_vsync   <= vs_act ? VS_ON : ~VS_ON;
      frame_start <= (cx == '0) && (cy == '0);
      if (!visible) begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end else if (tm_line) begin
        vga_r <= {8{bar_idx[2]}};
        vga_g <= {8{bar_idx[1]}};
        vga_b <= {8{bar_idx[0]}};
      end else begin
        vga_r <= px_r;
        vga_g <= px_g;
        vga_b <= px_b;
      end
    end
  end

endmodule
